display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder, common-anode digits,
// dead-time blanking between digits and frame-boundary double buffering of display data.
module display_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZB          = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     digit_en_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     an_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [IW-1:0]     IDX_ONE    = IW'(1);
  localparam logic [DIGITS-1:0] AN_ONE     = DIGITS'(1);

  typedef enum logic [0:0] {
    S_SHOW  = 1'b0,
    S_BLANK = 1'b1
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [CW-1:0]            r_cnt, w_cnt_nxt;
  logic [IW-1:0]            r_idx, w_idx_nxt;
  logic                     w_wrap;

  logic [DIGITS-1:0][3:0]   r_act_dig, w_act_dig_nxt;
  logic [DIGITS-1:0]        r_act_en, w_act_en_nxt;
  logic [DIGITS-1:0]        r_act_dp, w_act_dp_nxt;
  logic [DIGITS-1:0][3:0]   r_pend_dig, w_pend_dig_nxt;
  logic [DIGITS-1:0]        r_pend_en, w_pend_en_nxt;
  logic [DIGITS-1:0]        r_pend_dp, w_pend_dp_nxt;
  logic                     r_pend_valid, w_pend_valid_nxt;

  logic [DIGITS-1:0]        w_lzb;
  logic [DIGITS-1:0]        w_vis;

  logic [3:0]               r_bcd, w_bcd_nxt;
  logic [DIGITS-1:0]        r_an_n, w_an_nxt;
  logic                     r_dp_n, w_dp_nxt;
  logic                     r_frame_done, w_frame_done_nxt;

  // Slot sequencing: SHOW for REFRESH_DIV cycles, BLANK for BLANK_CYCLES, then next digit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    case (r_state)
      S_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_SHOW;
        end
      end
      S_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = S_SHOW;
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_ONE;
          end
        end else begin
          w_state_nxt = S_BLANK;
        end
      end
      default: begin
        w_state_nxt = S_SHOW;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Double buffer: loads park in pending; active only changes on the frame wrap edge.
  always_comb begin
    w_act_dig_nxt    = r_act_dig;
    w_act_en_nxt     = r_act_en;
    w_act_dp_nxt     = r_act_dp;
    w_pend_dig_nxt   = r_pend_dig;
    w_pend_en_nxt    = r_pend_en;
    w_pend_dp_nxt    = r_pend_dp;
    w_pend_valid_nxt = r_pend_valid;
    if (w_wrap) begin
      if (load) begin
        w_act_dig_nxt = digits_in;
        w_act_en_nxt  = digit_en_in;
        w_act_dp_nxt  = dp_in;
      end else if (r_pend_valid) begin
        w_act_dig_nxt = r_pend_dig;
        w_act_en_nxt  = r_pend_en;
        w_act_dp_nxt  = r_pend_dp;
      end else begin
        w_act_dig_nxt = r_act_dig;
      end
      w_pend_valid_nxt = 1'b0;
    end else if (load) begin
      w_pend_dig_nxt   = digits_in;
      w_pend_en_nxt    = digit_en_in;
      w_pend_dp_nxt    = dp_in;
      w_pend_valid_nxt = 1'b1;
    end else begin
      w_pend_valid_nxt = r_pend_valid;
    end
  end

  // Visibility per digit; leading zeros scan downward and skip disabled digits.
  always_comb begin
    logic v_zero_above;
    v_zero_above = 1'b1;
    w_lzb        = '0;
    w_vis        = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_lzb[i] = (LZB != 0) && (i != 0) && (w_act_dig_nxt[i] == 4'd0) && v_zero_above;
      v_zero_above = v_zero_above && (!w_act_en_nxt[i] || (w_act_dig_nxt[i] == 4'd0));
      w_vis[i] = w_act_en_nxt[i] && (w_act_dig_nxt[i] <= 4'd9) && !w_lzb[i];
    end
  end

  // Output values for the cycle being entered; bcd holds through BLANK.
  always_comb begin
    w_an_nxt  = {DIGITS{1'b1}};
    w_dp_nxt  = 1'b1;
    w_bcd_nxt = r_bcd;
    if (w_state_nxt == S_SHOW) begin
      w_bcd_nxt = w_act_dig_nxt[w_idx_nxt];
      if (w_vis[w_idx_nxt]) begin
        w_an_nxt = ~(AN_ONE << w_idx_nxt);
        w_dp_nxt = ~w_act_dp_nxt[w_idx_nxt];
      end else begin
        w_an_nxt = {DIGITS{1'b1}};
      end
    end else begin
      w_bcd_nxt = r_bcd;
    end
    w_frame_done_nxt = (w_state_nxt == S_BLANK) && (w_idx_nxt == IDX_LAST) &&
                       (w_cnt_nxt == BLANK_LAST);
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_SHOW;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_act_dig    <= '0;
      r_act_en     <= '0;
      r_act_dp     <= '0;
      r_pend_dig   <= '0;
      r_pend_en    <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_bcd        <= 4'd0;
      r_an_n       <= {DIGITS{1'b1}};
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_act_dig    <= w_act_dig_nxt;
      r_act_en     <= w_act_en_nxt;
      r_act_dp     <= w_act_dp_nxt;
      r_pend_dig   <= w_pend_dig_nxt;
      r_pend_en    <= w_pend_en_nxt;
      r_pend_dp    <= w_pend_dp_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_bcd        <= w_bcd_nxt;
      r_an_n       <= w_an_nxt;
      r_dp_n       <= w_dp_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bcd_out    = r_bcd;
  assign an_n       = r_an_n;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a slot-position reference model,
// plus literal checks for the directed scenarios.
module tb_display_scan_ctrl;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int SL = RD + BC;
  localparam int FL = D * SL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  digit_en_in = 4'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle position since reset plus active/pending buffers.
  int          m_t = 0;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_en, m_dp;
  logic [3:0]  p_dig [4];
  logic [3:0]  p_en, p_dp;
  logic        m_pv;

  logic [3:0]  scan_an [0:19] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF,
                                   4'hD, 4'hD, 4'hD, 4'hD, 4'hF,
                                   4'hB, 4'hB, 4'hB, 4'hB, 4'hF,
                                   4'h7, 4'h7, 4'h7, 4'h7, 4'hF};
  logic [3:0]  scan_bcd [0:3] = '{4'd4, 4'd3, 4'd2, 4'd1};

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZB(1)
  ) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .digit_en_in(digit_en_in),
    .dp_in(dp_in), .load(load), .bcd_out(bcd_out), .an_n(an_n), .dp_n(dp_n),
    .frame_done(frame_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0d)", nm, act, exp, m_t);
    end
  endtask

  function automatic logic m_vis(input int d);
    logic all_zero;
    if (!m_en[d] || m_dig[d] > 4'd9) return 1'b0;
    if (d == 0 || m_dig[d] != 4'd0) return 1'b1;
    all_zero = 1'b1;
    for (int j = d + 1; j < D; j++)
      if (m_en[j] && m_dig[j] != 4'd0) all_zero = 1'b0;
    return !all_zero;
  endfunction

  task automatic m_step(input logic r, input logic ld, input logic [15:0] dg,
                        input logic [3:0] en, input logic [3:0] dp);
    if (r) begin
      m_t = 0;
      for (int i = 0; i < D; i++) begin m_dig[i] = 4'h0; p_dig[i] = 4'h0; end
      m_en = 4'h0; m_dp = 4'h0; p_en = 4'h0; p_dp = 4'h0; m_pv = 1'b0;
    end else begin
      if (m_t % FL == FL - 1) begin
        if (ld) begin
          for (int i = 0; i < D; i++) m_dig[i] = dg[4*i +: 4];
          m_en = en; m_dp = dp;
        end else if (m_pv) begin
          for (int i = 0; i < D; i++) m_dig[i] = p_dig[i];
          m_en = p_en; m_dp = p_dp;
        end
        m_pv = 1'b0;
      end else if (ld) begin
        for (int i = 0; i < D; i++) p_dig[i] = dg[4*i +: 4];
        p_en = en; p_dp = dp; m_pv = 1'b1;
      end
      m_t++;
    end
  endtask

  task automatic m_compare();
    int pos, d;
    logic show, v;
    logic [3:0] e_an;
    logic e_dp;
    pos  = m_t % FL;
    d    = pos / SL;
    show = (pos % SL) < RD;
    v    = show && m_vis(d);
    e_an = v ? ~(4'b0001 << d) : 4'b1111;
    e_dp = v ? ~m_dp[d] : 1'b1;
    chk("an_n", an_n, e_an);
    chk("dp_n", dp_n, e_dp);
    chk("bcd_out", bcd_out, m_dig[d]);
    chk("frame_done", frame_done, (pos == FL - 1));
  endtask

  task automatic tick(input logic r, input logic ld, input logic [15:0] dg,
                      input logic [3:0] en, input logic [3:0] dp);
    rst = r; load = ld; digits_in = dg; digit_en_in = en; dp_in = dp;
    @(posedge clk);
    m_step(r, ld, dg, en, dp);
    #1;
    m_compare();
  endtask

  task automatic tick_idle();
    tick(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < FL && (m_t % FL) != p; i++) tick_idle();
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  ren;
    logic        rr, rl;

    // Reset and idle: dark display, frame_done at cycles 19 and 39.
    tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    chk("rst_an", an_n, 4'b1111);
    chk("rst_dp", dp_n, 1'b1);
    chk("rst_bcd", bcd_out, 4'd0);
    chk("rst_fd", frame_done, 1'b0);
    for (int k = 1; k < 40; k++) begin
      tick_idle();
      chk("idle_an", an_n, 4'b1111);
      chk("idle_fd", frame_done, (k == 19 || k == 39));
    end

    // Basic scan of 0x1234 from the next frame boundary.
    tick_idle();
    tick(1'b0, 1'b1, 16'h1234, 4'hF, 4'h0);
    wait_pos(0);
    for (int i = 0; i < 20; i++) begin
      chk("scan_an", an_n, scan_an[i]);
      if ((i % SL) < RD) chk("scan_bcd", bcd_out, scan_bcd[i / SL]);
      tick_idle();
    end

    // Mid-frame load waits for the boundary; load on frame_done applies immediately.
    wait_pos(7);
    tick(1'b0, 1'b1, 16'h5678, 4'hF, 4'h0);
    wait_pos(15);
    chk("latch_old_bcd", bcd_out, 4'd1);
    chk("latch_old_an", an_n, 4'b0111);
    wait_pos(0);
    chk("latch_new_bcd", bcd_out, 4'd8);
    chk("latch_new_an", an_n, 4'b1110);
    wait_pos(19);
    chk("wrap_fd", frame_done, 1'b1);
    tick(1'b0, 1'b1, 16'h4321, 4'hF, 4'h0);
    chk("wrapload_bcd", bcd_out, 4'd1);
    wait_pos(5);
    chk("wrapload_bcd1", bcd_out, 4'd2);

    // Leading-zero blanking.
    wait_pos(19);
    tick(1'b0, 1'b1, 16'h0070, 4'hF, 4'h0);
    chk("lzb_d0_an", an_n, 4'b1110);
    chk("lzb_d0_bcd", bcd_out, 4'd0);
    wait_pos(5);
    chk("lzb_d1_an", an_n, 4'b1101);
    chk("lzb_d1_bcd", bcd_out, 4'd7);
    wait_pos(10);
    chk("lzb_d2_an", an_n, 4'b1111);
    wait_pos(15);
    chk("lzb_d3_an", an_n, 4'b1111);

    // Invalid code blanks the digit and its decimal point.
    wait_pos(19);
    tick(1'b0, 1'b1, 16'h00A5, 4'hF, 4'b0010);
    chk("inv_d0_an", an_n, 4'b1110);
    chk("inv_d0_bcd", bcd_out, 4'd5);
    wait_pos(5);
    chk("inv_d1_an", an_n, 4'b1111);
    chk("inv_d1_dp", dp_n, 1'b1);

    // Disabled digits keep their slot; dp only where enabled.
    wait_pos(19);
    tick(1'b0, 1'b1, 16'h9999, 4'b0101, 4'b0001);
    chk("dis_d0_an", an_n, 4'b1110);
    chk("dis_d0_dp", dp_n, 1'b0);
    wait_pos(5);
    chk("dis_d1_an", an_n, 4'b1111);
    wait_pos(10);
    chk("dis_d2_an", an_n, 4'b1011);
    chk("dis_d2_dp", dp_n, 1'b1);
    wait_pos(19);
    chk("dis_fd", frame_done, 1'b1);

    // Reset during digit 2 SHOW with a pending load discards everything.
    wait_pos(3);
    tick(1'b0, 1'b1, 16'h8888, 4'hF, 4'hF);
    wait_pos(10);
    chk("pre_rst_an", an_n, 4'b1011);
    tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    chk("mid_rst_an", an_n, 4'b1111);
    chk("mid_rst_dp", dp_n, 1'b1);
    chk("mid_rst_bcd", bcd_out, 4'd0);
    for (int k = 0; k < 40; k++) begin
      tick_idle();
      chk("post_rst_an", an_n, 4'b1111);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < D; i++)
        rd[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      rr  = ($urandom_range(0, 499) == 0);
      rl  = ($urandom_range(0, 7) == 0);
      tick(rr, rl, rd, ren, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
